// File: rtl/ip2_dnn_output_emulator.sv
// Cycle-accurate IP2 DNN output emulator: trigger -> fixed inference latency -> MSB-first serialization
// of two result words. Define IP2_DNN_EMU_LFSR_EN to source the words from an internal 48-bit LFSR.
module ip2_dnn_output_emulator #(
    parameter int INFER_LATENCY = 20,
    parameter int DNN_WIDTH     = 48
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 dut_i_reset_not,
    input  logic                 dut_i_vin_test_trig_out,
    input  logic                 dut_i_scan_load,
    input  logic [5:0]           shift_start_delay,
    input  logic [DNN_WIDTH-1:0] dnn_pattern_0,
    input  logic [DNN_WIDTH-1:0] dnn_pattern_1,
    output logic                 dut_o_dnn_output_0,
    output logic                 dut_o_dnn_output_1,
    output logic [2:0]           emu_state,
    output logic                 emu_o_result_valid,
    output logic [7:0]           emu_o_trig_count,
    output logic                 emu_o_overrun
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_INFER = 3'd1;
    localparam logic [2:0] ST_READY = 3'd2;
    localparam logic [2:0] ST_DELAY = 3'd3;
    localparam logic [2:0] ST_SHIFT = 3'd4;

    localparam int CNT_W = (INFER_LATENCY > 1) ? $clog2(INFER_LATENCY) : 1;
    localparam int BIT_W = $clog2(DNN_WIDTH);

    logic [2:0]           state_q,     state_d;
    logic [CNT_W-1:0]     infer_cnt_q, infer_cnt_d;
    logic [5:0]           delay_cnt_q, delay_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,   bit_cnt_d;
    logic [DNN_WIDTH-1:0] word0_q,     word0_d;
    logic [DNN_WIDTH-1:0] word1_q,     word1_d;
    logic                 out0_q,      out0_d;
    logic                 out1_q,      out1_d;
    logic                 valid_q,     valid_d;
    logic [7:0]           trig_cnt_q,  trig_cnt_d;
    logic                 overrun_q,   overrun_d;
    logic                 trig_prev_q, trig_prev_d;
    logic                 trig_rise_s;
    logic                 start_shift_s;

`ifdef IP2_DNN_EMU_LFSR_EN
    logic [DNN_WIDTH-1:0] lfsr_q, lfsr_d;
    logic [DNN_WIDTH-1:0] lfsr_next_s;

    // Fibonacci LFSR, taps 48,47,21,20, shifting towards the MSB
    function automatic logic [DNN_WIDTH-1:0] lfsr_step(input logic [DNN_WIDTH-1:0] s);
        lfsr_step = {s[DNN_WIDTH-2:0], s[47] ^ s[46] ^ s[20] ^ s[19]};
    endfunction
`endif

    // Next-state logic for the whole emulator
    always_comb begin
        state_d       = state_q;
        infer_cnt_d   = infer_cnt_q;
        delay_cnt_d   = delay_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        word0_d       = word0_q;
        word1_d       = word1_q;
        out0_d        = out0_q;
        out1_d        = out1_q;
        valid_d       = valid_q;
        trig_cnt_d    = trig_cnt_q;
        overrun_d     = overrun_q;
        trig_prev_d   = dut_i_vin_test_trig_out;
        trig_rise_s   = dut_i_vin_test_trig_out & ~trig_prev_q;
        start_shift_s = 1'b0;
`ifdef IP2_DNN_EMU_LFSR_EN
        lfsr_next_s   = lfsr_step(lfsr_q);
        lfsr_d        = lfsr_q;
`endif

        if (!enable) begin
            state_d     = ST_IDLE;
            infer_cnt_d = {CNT_W{1'b0}};
            delay_cnt_d = 6'd0;
            bit_cnt_d   = {BIT_W{1'b0}};
            word0_d     = {DNN_WIDTH{1'b0}};
            word1_d     = {DNN_WIDTH{1'b0}};
            out0_d      = 1'b0;
            out1_d      = 1'b0;
            valid_d     = 1'b0;
            trig_cnt_d  = 8'd0;
            overrun_d   = 1'b0;
            trig_prev_d = 1'b1;
`ifdef IP2_DNN_EMU_LFSR_EN
            lfsr_d      = {{(DNN_WIDTH-1){1'b0}}, 1'b1};
`endif
        end else if (!dut_i_reset_not) begin
            // ASIC held in reset: abort silently, keep the sticky diagnostics
            state_d = ST_IDLE;
            out0_d  = 1'b0;
            out1_d  = 1'b0;
            valid_d = 1'b0;
        end else begin
            if (trig_rise_s) begin
                trig_cnt_d = trig_cnt_q + 8'd1;
                if (state_q != ST_IDLE) begin
                    overrun_d = 1'b1;
                end else begin
                    overrun_d = overrun_q;
                end
            end else begin
                trig_cnt_d = trig_cnt_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (trig_rise_s) begin
                        state_d     = ST_INFER;
                        infer_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_INFER: begin
                    if (infer_cnt_q == CNT_W'(INFER_LATENCY - 1)) begin
`ifdef IP2_DNN_EMU_LFSR_EN
                        word0_d = lfsr_next_s;
                        word1_d = ~lfsr_next_s;
                        lfsr_d  = lfsr_next_s;
`else
                        word0_d = dnn_pattern_0;
                        word1_d = dnn_pattern_1;
`endif
                        valid_d = 1'b1;
                        state_d = ST_READY;
                    end else begin
                        infer_cnt_d = infer_cnt_q + CNT_W'(1);
                    end
                end
                ST_READY: begin
                    if (dut_i_scan_load) begin
                        if (shift_start_delay == 6'd0) begin
                            start_shift_s = 1'b1;
                        end else begin
                            delay_cnt_d = shift_start_delay;
                            state_d     = ST_DELAY;
                        end
                    end else begin
                        state_d = ST_READY;
                    end
                end
                ST_DELAY: begin
                    if (delay_cnt_q == 6'd1) begin
                        start_shift_s = 1'b1;
                    end else begin
                        delay_cnt_d = delay_cnt_q - 6'd1;
                    end
                end
                ST_SHIFT: begin
                    if (bit_cnt_q == {BIT_W{1'b0}}) begin
                        out0_d  = 1'b0;
                        out1_d  = 1'b0;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        out0_d    = word0_q[DNN_WIDTH-1];
                        out1_d    = word1_q[DNN_WIDTH-1];
                        word0_d   = {word0_q[DNN_WIDTH-2:0], 1'b0};
                        word1_d   = {word1_q[DNN_WIDTH-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q - BIT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    out0_d  = 1'b0;
                    out1_d  = 1'b0;
                    valid_d = 1'b0;
                end
            endcase

            // The MSB goes out on the same edge that enters SHIFT
            if (start_shift_s) begin
                out0_d    = word0_q[DNN_WIDTH-1];
                out1_d    = word1_q[DNN_WIDTH-1];
                word0_d   = {word0_q[DNN_WIDTH-2:0], 1'b0};
                word1_d   = {word1_q[DNN_WIDTH-2:0], 1'b0};
                bit_cnt_d = BIT_W'(DNN_WIDTH - 1);
                state_d   = ST_SHIFT;
            end else begin
                start_shift_s = 1'b0;
            end
        end
    end

    // State registers; trig_prev resets high so a trigger held across reset is not an edge
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            infer_cnt_q <= {CNT_W{1'b0}};
            delay_cnt_q <= 6'd0;
            bit_cnt_q   <= {BIT_W{1'b0}};
            word0_q     <= {DNN_WIDTH{1'b0}};
            word1_q     <= {DNN_WIDTH{1'b0}};
            out0_q      <= 1'b0;
            out1_q      <= 1'b0;
            valid_q     <= 1'b0;
            trig_cnt_q  <= 8'd0;
            overrun_q   <= 1'b0;
            trig_prev_q <= 1'b1;
`ifdef IP2_DNN_EMU_LFSR_EN
            lfsr_q      <= {{(DNN_WIDTH-1){1'b0}}, 1'b1};
`endif
        end else begin
            state_q     <= state_d;
            infer_cnt_q <= infer_cnt_d;
            delay_cnt_q <= delay_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            word0_q     <= word0_d;
            word1_q     <= word1_d;
            out0_q      <= out0_d;
            out1_q      <= out1_d;
            valid_q     <= valid_d;
            trig_cnt_q  <= trig_cnt_d;
            overrun_q   <= overrun_d;
            trig_prev_q <= trig_prev_d;
`ifdef IP2_DNN_EMU_LFSR_EN
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign dut_o_dnn_output_0 = out0_q;
    assign dut_o_dnn_output_1 = out1_q;
    assign emu_state          = state_q;
    assign emu_o_result_valid = valid_q;
    assign emu_o_trig_count   = trig_cnt_q;
    assign emu_o_overrun      = overrun_q;

endmodule

// File: tb/tb_ip2_dnn_output_emulator.sv
// Self-checking bench for ip2_dnn_output_emulator: directed scenarios plus random traffic,
// compared every cycle against a timeline-based reference model.
module tb_ip2_dnn_output_emulator;

    localparam int L = 20;
    localparam int W = 48;

    logic        clk = 1'b0;
    logic        reset, enable, rn, trig, sl;
    logic [5:0]  dly;
    logic [47:0] p0, p1;
    logic        out0, out1, valid, ovr_o;
    logic [2:0]  st;
    logic [7:0]  cnt_o;

    int checks = 0;
    int errors = 0;

    // Reference model: a sequence is a set of absolute edge times
    int          n;
    bit          busy, have_e, prev;
    int          t_valid, t_first, t_end;
    logic [47:0] w0, w1, lfsr;
    int          cnt;
    bit          ovr;

    always #5 clk = ~clk;

    ip2_dnn_output_emulator #(.INFER_LATENCY(L), .DNN_WIDTH(W)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .dut_i_reset_not(rn), .dut_i_vin_test_trig_out(trig), .dut_i_scan_load(sl),
        .shift_start_delay(dly), .dnn_pattern_0(p0), .dnn_pattern_1(p1),
        .dut_o_dnn_output_0(out0), .dut_o_dnn_output_1(out1), .emu_state(st),
        .emu_o_result_valid(valid), .emu_o_trig_count(cnt_o), .emu_o_overrun(ovr_o)
    );

    function automatic void model_clear();
        busy = 1'b0; have_e = 1'b0; prev = 1'b1;
        w0 = '0; w1 = '0; cnt = 0; ovr = 1'b0; lfsr = 48'h1;
    endfunction

    task automatic model_edge();
        bit rise;
        n++;
        if (!enable) begin
            model_clear();
            return;
        end
        rise = trig && !prev;
        prev = trig;
        if (!rn) begin
            busy = 1'b0;
            return;
        end
        if (busy) begin
            if (rise) begin
                cnt = (cnt + 1) % 256;
                ovr = 1'b1;
            end
            if (n == t_valid) begin
`ifdef IP2_DNN_EMU_LFSR_EN
                lfsr = {lfsr[46:0], lfsr[47] ^ lfsr[46] ^ lfsr[20] ^ lfsr[19]};
                w0 = lfsr;
                w1 = ~lfsr;
`else
                w0 = p0;
                w1 = p1;
`endif
            end else if (have_e && n == t_end) begin
                busy = 1'b0;
            end else if (!have_e && n > t_valid && sl) begin
                have_e  = 1'b1;
                t_first = n + int'(dly);
                t_end   = t_first + W;
            end
        end else if (rise) begin
            busy    = 1'b1;
            have_e  = 1'b0;
            t_valid = n + L;
            cnt     = (cnt + 1) % 256;
        end
    endtask

    function automatic int exp_state();
        if (!busy)           return 0;
        if (n < t_valid)     return 1;
        if (!have_e)         return 2;
        if (n < t_first)     return 3;
        return 4;
    endfunction

    function automatic logic exp_bit(input logic [47:0] w);
        int idx;
        if (!(busy && have_e && n >= t_first)) return 1'b0;
        idx = W - 1 - (n - t_first);
        return w[idx];
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"}, 64'(st), 64'(exp_state()));
        chk({tag, ".out0"}, 64'(out0), 64'(exp_bit(w0)));
        chk({tag, ".out1"}, 64'(out1), 64'(exp_bit(w1)));
        chk({tag, ".valid"}, 64'(valid), 64'(busy && n >= t_valid));
        chk({tag, ".count"}, 64'(cnt_o), 64'(cnt));
        chk({tag, ".overrun"}, 64'(ovr_o), 64'(ovr));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    logic [47:0] cap0, cap1, exp0, exp1;

    initial begin
        reset = 1'b1; enable = 1'b1; rn = 1'b1; trig = 1'b0; sl = 1'b0;
        dly = 6'd0; p0 = 48'h0; p1 = 48'h0;
        n = 0; t_valid = 0; t_first = 0; t_end = 0;
        model_clear();
        #2;
        check_all("reset");
        @(negedge clk);
        reset = 1'b0;

        // Basic sequence
        rn = 1'b0;
        repeat (64) step("rn_low");
        rn = 1'b1;
        step("rn_rel");
        p0 = 48'hA5A5_0F0F_1234; p1 = 48'h0000_0000_0001;
        trig = 1'b1;
        step("basic_trig");
        trig = 1'b0;
        repeat (39) step("basic_wait");
        sl = 1'b1;
        cap0 = '0; cap1 = '0;
        for (int i = 0; i < W; i++) begin
            step("basic_shift");
            cap0 = {cap0[46:0], out0};
            cap1 = {cap1[46:0], out1};
        end
`ifdef IP2_DNN_EMU_LFSR_EN
        exp0 = 48'h0000_0000_0002;
`else
        exp0 = 48'hA5A5_0F0F_1234;
`endif
`ifdef IP2_DNN_EMU_LFSR_EN
        exp1 = ~exp0;
`else
        exp1 = 48'h0000_0000_0001;
`endif
        chk("basic_line0", 64'(cap0), 64'(exp0));
        chk("basic_line1", 64'(cap1), 64'(exp1));
        step("basic_end");
        chk("basic_idle", 64'(st), 64'd0);
        chk("basic_count", 64'(cnt_o), 64'd1);
        sl = 1'b0;

        // Pre-asserted scan_load with start delay
        sl = 1'b1; dly = 6'd5;
        p0 = {16'($urandom()), $urandom()}; p1 = {16'($urandom()), $urandom()};
        trig = 1'b1;
        step("pre_trig");
        trig = 1'b0;
        repeat (80) step("pre_run");
        cap1 = cap0;
        chk("pre_count", 64'(cnt_o), 64'd2);

        // Overrun during INFER
        sl = 1'b0; dly = 6'd0;
        trig = 1'b1;
        step("ovr_trig");
        trig = 1'b0;
        repeat (9) step("ovr_infer");
        trig = 1'b1;
        step("ovr_trig2");
        trig = 1'b0;
        repeat (30) step("ovr_ready");
        chk("ovr_flag", 64'(ovr_o), 64'd1);
        chk("ovr_count", 64'(cnt_o), 64'd4);
        sl = 1'b1;
        repeat (55) step("ovr_shift");

        // reset_not abort mid-shift
        sl = 1'b0;
        trig = 1'b1;
        step("abort_trig");
        trig = 1'b0;
        repeat (25) step("abort_wait");
        sl = 1'b1;
        repeat (21) step("abort_shift");
        rn = 1'b0; trig = 1'b1;
        step("abort_rn");
        chk("abort_state", 64'(st), 64'd0);
        chk("abort_valid", 64'(valid), 64'd0);
        trig = 1'b0;
        step("abort_low");
        trig = 1'b1;
        step("abort_low_trig");
        chk("abort_nocount", 64'(cnt_o), 64'd5);
        trig = 1'b0; rn = 1'b1;
        step("abort_rel");

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) trig = ~trig;
            rn  = ($urandom_range(0, 149) != 0);
            if ($urandom_range(0, 9) == 0) sl = ~sl;
            dly = ($urandom_range(0, 7) == 0) ? 6'd63 : 6'($urandom_range(0, 6));
            p0  = {16'($urandom()), $urandom()};
            p1  = {16'($urandom()), $urandom()};
            step("rand");
        end

        // 256 trigger rises wrap the counter
        rn = 1'b1; sl = 1'b1; trig = 1'b0;
        step("wrap_pre");
        cap0 = 48'(cnt);
        for (int i = 0; i < 256; i++) begin
            trig = 1'b1;
            step("wrap_hi");
            trig = 1'b0;
            step("wrap_lo");
        end
        chk("wrap_count", 64'(cnt_o), 64'(cap0));

        // Synchronous clear
        enable = 1'b0;
        step("en_clear");
        chk("en_count", 64'(cnt_o), 64'd0);
        chk("en_state", 64'(st), 64'd0);
        enable = 1'b1; sl = 1'b0;
        step("en_rel");

        // Async reset mid-INFER
        trig = 1'b1;
        step("ar_trig");
        trig = 1'b0;
        repeat (5) step("ar_infer");
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_clear();
        check_all("ar_now");
        chk("ar_state", 64'(st), 64'd0);
        reset = 1'b0;
        repeat (5) step("ar_after");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
